// File: rtl/dili_pwm.sv
// dili_pwm: streaming pointwise Montgomery multiplier, c = a*b*2^-32 mod q, over framed NTT-domain coefficients.
// Optional macro DILI_PWM_FREEZE_EN adds a final stage that maps c_o into [0, q).
module dili_pwm #(
   parameter int N    = 256,
   parameter int Q    = 8380417,
   parameter int QINV = 58728449
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic signed [31:0] a_i,
   input  logic signed [31:0] b_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic signed [31:0] c_o,
   output logic [7:0]         out_idx_o,
   output logic               out_last_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [1:0]         dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [7:0]         LAST_IDX = 8'(N - 1);
   localparam logic [31:0]        QINV_U   = 32'(QINV);
   localparam logic signed [63:0] Q_S64    = 64'(Q);

   state_t             r_state, w_state_nxt;
   logic [7:0]         r_in_cnt, r_out_cnt;
   logic               r_v1, r_v2, r_v3;
   logic signed [63:0] r_p1, r_p2;
   logic signed [31:0] r_t2, r_c3;
   logic               w_adv, w_acc, w_out_xfer, w_v_last, w_in_last;
   logic [31:0]        w_t;
   logic signed [63:0] w_a64, w_b64, w_t64, w_tq, w_diff;
   logic signed [31:0] w_c;

   // Handshake: a beat moves on a side only when valid and ready are both high at the
   // clock edge; the whole pipeline advances together, and freezes while the last
   // stage holds a beat that downstream refuses, so in_ready follows out_ready combinationally.
   assign w_adv      = !w_v_last || out_ready_i;
   assign in_ready_o = (r_state == ST_RUN) && w_adv;
   assign w_acc      = in_valid_i && in_ready_o;
   assign w_out_xfer = w_v_last && out_ready_i;
   assign w_in_last  = (r_in_cnt == LAST_IDX);

   assign w_a64  = {{32{a_i[31]}}, a_i};
   assign w_b64  = {{32{b_i[31]}}, b_i};
   assign w_t    = r_p1[31:0] * QINV_U;
   assign w_t64  = {{32{r_t2[31]}}, r_t2};
   assign w_tq   = w_t64 * Q_S64;
   // Low 32 bits of the difference are zero by construction of t.
   assign w_diff = r_p2 - w_tq;
   assign w_c    = 32'(w_diff >>> 32);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
         r_c3 <= '0;
      end else if (w_adv) begin
         r_v1 <= w_acc;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         r_c3 <= w_c;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_adv) begin
         r_p1 <= w_a64 * w_b64;
         r_p2 <= r_p1;
         r_t2 <= w_t;
      end
   end

`ifdef DILI_PWM_FREEZE_EN
   logic               r_v4;
   logic signed [31:0] r_c4;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_v4 <= 1'b0;
         r_c4 <= '0;
      end else if (w_adv) begin
         r_v4 <= r_v3;
         r_c4 <= r_c3[31] ? (r_c3 + 32'(Q)) : r_c3;
      end
   end

   assign w_v_last = r_v4;
   assign c_o      = r_c4;
`else
   assign w_v_last = r_v3;
   assign c_o      = r_c3;
`endif

   assign out_valid_o = w_v_last;
   assign out_idx_o   = r_out_cnt;
   assign out_last_o  = w_v_last && (r_out_cnt == LAST_IDX);
   assign dbg_state_o = r_state;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start_i) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy_o = 1'b1;
            if (w_acc && w_in_last) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy_o = 1'b1;
            if (w_out_xfer && out_last_o) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else if ((r_state == ST_IDLE) && start_i) begin
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_acc)      r_in_cnt  <= r_in_cnt + 8'd1;
         if (w_out_xfer) r_out_cnt <= r_out_cnt + 8'd1;
      end
   end

endmodule
